alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one conditional operation at a time to an external
// combinational ALU, captures its result/flags and holds them until consumed.
module alu_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_ctrl,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [1:0]   in_cond,
  input  logic         in_setflags,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic         out_executed,
  output logic         out_err,
  output logic [3:0]   flags_q
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_EXEC  = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [3:0] CTRL_NOP = 4'b1111;

  logic [1:0]   state_r;
  logic [1:0]   state_s;
  logic         accept_s;
  logic         err_s;
  logic         exec_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         setflags_r;
  logic         err_r;
  logic         exec_r;
  logic [N-1:0] alu_a_r;
  logic [N-1:0] alu_b_r;
  logic [3:0]   alu_ctrl_r;
  logic [N-1:0] out_result_r;
  logic [3:0]   out_flags_r;
  logic         out_executed_r;
  logic         out_err_r;
  logic [3:0]   flags_r;

  // Condition codes read the flag nibble as [3]=N [2]=Z [1]=V [0]=C.
  function automatic logic cond_pass(input logic [1:0] cond, input logic [3:0] flags);
    logic pass;
    case (cond)
      2'b00:   pass = 1'b1;
      2'b01:   pass = flags[2];
      2'b10:   pass = ~flags[2];
      2'b11:   pass = flags[3] ^ flags[1];
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Undefined opcodes and divide/modulo by zero are rejected without touching the ALU.
  function automatic logic op_rejected(input logic [3:0] ctrl, input logic [N-1:0] b);
    logic bad;
    if (ctrl >= 4'b1001) begin
      bad = 1'b1;
    end else if ((ctrl == 4'b0100) || (ctrl == 4'b1000)) begin
      bad = (b == {N{1'b0}});
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // Next-state logic for the IDLE -> EXEC -> DONE loop.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_s = ST_EXEC;
        else          state_s = ST_IDLE;
      end
      ST_EXEC: state_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // flags_q cannot change between acceptance and EXEC, so the execute decision
  // is taken at acceptance, which lets the ALU drive come straight from flops.
  always_comb begin
    accept_s = 1'b0;
    err_s    = 1'b0;
    exec_s   = 1'b0;
    if ((state_r == ST_IDLE) && in_valid) begin
      accept_s = 1'b1;
      err_s    = op_rejected(in_ctrl, in_b);
      exec_s   = ~err_s & cond_pass(in_cond, flags_r);
    end else begin
      accept_s = 1'b0;
    end
  end

  // State register and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  // ALU drive: operands only during an executing EXEC cycle, NOP otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r    <= {N{1'b0}};
      alu_b_r    <= {N{1'b0}};
      alu_ctrl_r <= CTRL_NOP;
    end else if (accept_s && exec_s) begin
      alu_a_r    <= in_a;
      alu_b_r    <= in_b;
      alu_ctrl_r <= in_ctrl;
    end else if (accept_s || (state_r == ST_EXEC)) begin
      alu_a_r    <= {N{1'b0}};
      alu_b_r    <= {N{1'b0}};
      alu_ctrl_r <= CTRL_NOP;
    end else begin
      alu_a_r    <= alu_a_r;
      alu_b_r    <= alu_b_r;
      alu_ctrl_r <= alu_ctrl_r;
    end
  end

  // Per-op attributes latched at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setflags_r <= 1'b0;
      err_r      <= 1'b0;
      exec_r     <= 1'b0;
    end else if (accept_s) begin
      setflags_r <= in_setflags;
      err_r      <= err_s;
      exec_r     <= exec_s;
    end else begin
      setflags_r <= setflags_r;
      err_r      <= err_r;
      exec_r     <= exec_r;
    end
  end

  // Result capture on the EXEC -> DONE edge; held until the next op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_r   <= {N{1'b0}};
      out_flags_r    <= 4'b0000;
      out_executed_r <= 1'b0;
      out_err_r      <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      out_result_r   <= exec_r ? alu_result : {N{1'b0}};
      out_flags_r    <= exec_r ? alu_flags : 4'b0000;
      out_executed_r <= exec_r;
      out_err_r      <= err_r;
    end else begin
      out_result_r   <= out_result_r;
      out_flags_r    <= out_flags_r;
      out_executed_r <= out_executed_r;
      out_err_r      <= out_err_r;
    end
  end

  // Architectural flags follow the ALU only for executed ops that request it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if ((state_r == ST_EXEC) && exec_r && setflags_r) begin
      flags_r <= alu_flags;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_ctrl     = alu_ctrl_r;
  assign out_result   = out_result_r;
  assign out_flags    = out_flags_r;
  assign out_executed = out_executed_r;
  assign out_err      = out_err_r;
  assign flags_q      = flags_r;

endmodule
